// File: rtl/keypad_controller.sv
// Purpose : 10-key decimal keypad front end: 2-flop sync, priority encode, debounce, load strobe.
// Latency : key stable from edge k -> loadn low after edge k+2+DB_CYCLES (k+3 without debounce).
// Backpres: none; enablen=1 parks the FSM in IDLE (loadn=1, pgt=0, out holds).
// Option  : define KEYPAD_DEBOUNCE_EN to enable DB_CYCLES press/release debounce counting.
module keypad_controller #(
    parameter int DB_CYCLES = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] keypad,
    input  logic       enablen,
    output logic [3:0] out,
    output logic       loadn,
    output logic       pgt
);

    // Counter wide enough for DB_CYCLES (1..15).
    localparam int CW = $clog2(DB_CYCLES + 1);

`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [CW-1:0] DB_LIMIT = CW'(DB_CYCLES);
`else
    // A limit of one makes PRESS_DB/REL_DB single-cycle qualification states.
    localparam logic [CW-1:0] DB_LIMIT = CW'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_DB,
        S_LOAD,
        S_HOLD,
        S_REL_DB
    } state_t;

    logic [9:0]    r_sync1;
    logic [9:0]    r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_cand;
    logic [3:0]    w_cand_nxt;
    logic [3:0]    w_code;
    logic          w_valid;
    logic [3:0]    r_out;
    logic          r_loadn;
    logic          r_pgt;

    // Two-flop synchronizer for the asynchronous key inputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keypad;
            r_sync2 <= r_sync1;
        end
    end

    // Priority encoder: highest pressed digit wins.
    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_sync2[i]) begin
                w_code = 4'(i);
            end
        end
        w_valid = |r_sync2;
    end

    // Next-state logic: debounce press, single load cycle, hold, debounce release.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = S_PRESS_DB;
                    w_cand_nxt  = w_code;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_PRESS_DB: begin
                // A release or a different key throws the candidate away.
                if (!w_valid || (w_code != r_cand)) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == DB_LIMIT) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_LOAD: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // Code changes while held are ignored; only a full release matters.
                if (!w_valid) begin
                    w_state_nxt = S_REL_DB;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_REL_DB: begin
                if (w_valid) begin
                    w_state_nxt = S_HOLD;
                end else if (r_cnt == DB_LIMIT) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Disabled block is parked in IDLE; synchronizer keeps running.
        if (enablen) begin
            w_state_nxt = S_IDLE;
        end
    end

    // FSM state, debounce counter and candidate code registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out   <= 4'd0;
            r_loadn <= 1'b1;
            r_pgt   <= 1'b0;
        end else begin
            r_loadn <= (w_state_nxt != S_LOAD);
            r_pgt   <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_HOLD) ||
                       (w_state_nxt == S_REL_DB);
            if (w_state_nxt == S_LOAD) begin
                r_out <= r_cand;
            end
        end
    end

    assign out   = r_out;
    assign loadn = r_loadn;
    assign pgt   = r_pgt;

endmodule

// File: tb/tb_keypad_controller.sv
// Purpose : directed self-checking bench for keypad_controller.
// Latency : expected load/release latency derived from the build option.
// Backpres: n/a.
module tb_keypad_controller;

    localparam int DB = 3;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT    = 2 + DB;
    localparam int GLITCH = DB - 1;
`else
    localparam int LAT    = 3;
    localparam int GLITCH = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [9:0] keypad;
    logic       enablen;
    logic [3:0] out;
    logic       loadn;
    logic       pgt;

    int n_checks = 0;
    int n_pass   = 0;
    int low_cnt  = 0;
    int pgt_cnt  = 0;

    keypad_controller #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .keypad  (keypad),
        .enablen (enablen),
        .out     (out),
        .loadn   (loadn),
        .pgt     (pgt)
    );

    always #5 clk = ~clk;

    // Count strobe-low cycles and press-good cycles away from the active edge.
    always @(negedge clk) begin
        if (loadn === 1'b0) low_cnt++;
        if (pgt === 1'b1) pgt_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn  = 1'b0;
        keypad  = '0;
        enablen = 1'b0;
        step(2);
        n_checks++; if (out !== 4'd0) $display("FAIL reset_out: got %0d want 0", out); else n_pass++;
        n_checks++; if (loadn !== 1'b1) $display("FAIL reset_loadn: got %b want 1", loadn); else n_pass++;
        n_checks++; if (pgt !== 1'b0) $display("FAIL reset_pgt: got %b want 0", pgt); else n_pass++;
        resetn = 1'b1;
        step(3);
    endtask

    task automatic test_single_key9;
        int l0;
        l0 = low_cnt;
        keypad = 10'b1000000000;
        step(LAT);
        n_checks++; if (loadn !== 1'b1) $display("FAIL k9_early_loadn: got %b want 1", loadn); else n_pass++;
        step(1);
        n_checks++; if (loadn !== 1'b0) $display("FAIL k9_loadn_low: got %b want 0", loadn); else n_pass++;
        n_checks++; if (out !== 4'd9) $display("FAIL k9_out: got %0d want 9", out); else n_pass++;
        n_checks++; if (pgt !== 1'b1) $display("FAIL k9_pgt_load: got %b want 1", pgt); else n_pass++;
        step(1);
        n_checks++; if (loadn !== 1'b1) $display("FAIL k9_loadn_one_cycle: got %b want 1", loadn); else n_pass++;
        step(10 - (LAT + 2));
        keypad = '0;
        step(LAT);
        n_checks++; if (pgt !== 1'b1) $display("FAIL k9_pgt_rel_hold: got %b want 1", pgt); else n_pass++;
        step(1);
        n_checks++; if (pgt !== 1'b0) $display("FAIL k9_pgt_rel_drop: got %b want 0", pgt); else n_pass++;
        step(5);
        n_checks++; if (low_cnt - l0 !== 1) $display("FAIL k9_pulses: got %0d want 1", low_cnt - l0); else n_pass++;
    endtask

    task automatic test_sequence;
        int l0;
        l0 = low_cnt;
        for (int d = 9; d >= 0; d--) begin
            keypad = 10'd1 << d;
            step(10);
            n_checks++; if (out !== 4'(d)) $display("FAIL seq_out: got %0d want %0d", out, d); else n_pass++;
            keypad = '0;
            step(10);
        end
        n_checks++; if (low_cnt - l0 !== 10) $display("FAIL seq_pulses: got %0d want 10", low_cnt - l0); else n_pass++;
    endtask

    task automatic test_two_keys;
        int l0;
        l0 = low_cnt;
        keypad = 10'b0000100100;
        step(10);
        n_checks++; if (out !== 4'd5) $display("FAIL two_keys_out: got %0d want 5", out); else n_pass++;
        n_checks++; if (low_cnt - l0 !== 1) $display("FAIL two_keys_pulses: got %0d want 1", low_cnt - l0); else n_pass++;
        keypad = '0;
        step(10);
    endtask

    task automatic test_glitch;
        int l0;
        int p0;
        l0 = low_cnt;
        p0 = pgt_cnt;
        keypad = 10'd1 << 7;
        step(GLITCH);
        keypad = '0;
        step(10);
        n_checks++; if (low_cnt - l0 !== 0) $display("FAIL glitch_pulses: got %0d want 0", low_cnt - l0); else n_pass++;
        n_checks++; if (out !== 4'd5) $display("FAIL glitch_out: got %0d want 5", out); else n_pass++;
        n_checks++; if (pgt_cnt - p0 !== 0) $display("FAIL glitch_pgt: got %0d high cycles want 0", pgt_cnt - p0); else n_pass++;
    endtask

    task automatic test_enable;
        int l0;
        int p0;
        l0 = low_cnt;
        p0 = pgt_cnt;
        enablen = 1'b1;
        keypad  = 10'd1 << 3;
        step(15);
        n_checks++; if (low_cnt - l0 !== 0) $display("FAIL dis_pulses: got %0d want 0", low_cnt - l0); else n_pass++;
        n_checks++; if (pgt_cnt - p0 !== 0) $display("FAIL dis_pgt: got %0d high cycles want 0", pgt_cnt - p0); else n_pass++;
        n_checks++; if (out !== 4'd5) $display("FAIL dis_out_hold: got %0d want 5", out); else n_pass++;
        enablen = 1'b0;
        step(15);
        n_checks++; if (low_cnt - l0 !== 1) $display("FAIL en_pulses: got %0d want 1", low_cnt - l0); else n_pass++;
        n_checks++; if (out !== 4'd3) $display("FAIL en_out: got %0d want 3", out); else n_pass++;
        n_checks++; if (pgt !== 1'b1) $display("FAIL en_pgt: got %b want 1", pgt); else n_pass++;
    endtask

    task automatic test_reset_midrun;
        // Key 3 still held and accepted; assert reset between edges.
        #3;
        resetn = 1'b0;
        #1;
        n_checks++; if (out !== 4'd0) $display("FAIL midrst_out: got %0d want 0", out); else n_pass++;
        n_checks++; if (loadn !== 1'b1) $display("FAIL midrst_loadn: got %b want 1", loadn); else n_pass++;
        n_checks++; if (pgt !== 1'b0) $display("FAIL midrst_pgt: got %b want 0", pgt); else n_pass++;
        keypad = '0;
        step(2);
        resetn = 1'b1;
        step(3);
        n_checks++; if (pgt !== 1'b0) $display("FAIL postrst_pgt: got %b want 0", pgt); else n_pass++;
        keypad = 10'd1 << 4;
        step(LAT);
        n_checks++; if (loadn !== 1'b1) $display("FAIL postrst_early_loadn: got %b want 1", loadn); else n_pass++;
        step(1);
        n_checks++; if (loadn !== 1'b0) $display("FAIL postrst_loadn: got %b want 0", loadn); else n_pass++;
        n_checks++; if (out !== 4'd4) $display("FAIL postrst_out: got %0d want 4", out); else n_pass++;
        keypad = '0;
        step(10);
    endtask

    initial begin
        test_reset;
        test_single_key9;
        test_sequence;
        test_two_keys;
        test_glitch;
        test_enable;
        test_reset_midrun;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
